tkx_update_param: RTL and testbench
===================================

TKX_UPDATE_PARAM -- requirements
Module: tkx_update_param

Interface
REQ-001 SHALL have parameter SDI_W, default 32: serial load beat width in bits; legal values 8, 16, 32, 64, 128.
REQ-002 SHALL have parameter ROUNDS, default 40: tweakey updates per run or rewind; legal range 1..127.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port sdi  input  SDI_W  serial tweakey load data.
REQ-006 SHALL have port sdi_valid  input  1  sdi beat offered.
REQ-007 SHALL have port sdi_ready  output  1  beat accepted when sdi_valid and sdi_ready are both high.
REQ-008 SHALL have port start  input  1  begin forward update run; honoured only in HOLD.
REQ-009 SHALL have port rewind  input  1  begin inverse update run; honoured only in HOLD.
REQ-010 SHALL have port clear  input  1  synchronous abort to IDLE.
REQ-011 SHALL have port skinny_tkx  input  128  next-round tweakey from the round function.
REQ-012 SHALL have port skinny_tkx_revert  input  128  previous-round tweakey from the inverse function.
REQ-013 SHALL have port tkx  output  128  registered tweakey state.
REQ-014 SHALL have port tkx_valid  output  1  high in HOLD only.
REQ-015 SHALL have port done  output  1  one-cycle pulse when a run or rewind completes.

Function
REQ-016 SHALL implement states IDLE, LOAD, HOLD, RUN and REWIND.
REQ-017 SHALL drive sdi_ready high in IDLE and LOAD and low in all other states.
REQ-018 SHALL shift on each accepted beat: tkx <= {tkx[127-SDI_W:0], sdi}, so the first beat ends in the most significant word.
REQ-019 SHALL move IDLE->LOAD on the first accepted beat and LOAD->HOLD on beat 128/SDI_W; with SDI_W=128, IDLE->HOLD on one beat.
REQ-020 SHALL hold tkx in HOLD; sdi_valid is ignored there.
REQ-021 SHALL, on start in HOLD, enter RUN and load tkx <= skinny_tkx on each of ROUNDS consecutive cycles, then return to HOLD.
REQ-022 SHALL, on rewind in HOLD, enter REWIND and load tkx <= skinny_tkx_revert on each of ROUNDS consecutive cycles, then return to HOLD.
REQ-023 SHALL give start priority over rewind when both are high in HOLD.
REQ-024 SHALL pulse done for exactly one cycle, the first HOLD cycle after RUN or REWIND; tkx_valid rises in that same cycle.
REQ-025 SHALL count with a round counter of width $clog2(ROUNDS+1) and a beat counter of width $clog2(128/SDI_W+1), both cleared on every state entry.
REQ-026 SHALL, on clear in any state, go to IDLE next cycle, zero both counters, suppress done and leave tkx unchanged; clear has priority over start, rewind and beats.
REQ-027 SHALL ignore start and rewind outside HOLD.
REQ-028 SHALL not change tkx in IDLE unless a beat is accepted.

Reset
REQ-029 SHALL, while rst is low, force tkx=0, state IDLE, counters 0, done=0, tkx_valid=0 and sdi_ready=1, independent of clk.
REQ-030 SHALL resume on the first rising clk edge after rst deasserts; reset mid-load or mid-run discards all progress.

Configuration
REQ-031 SHALL, with TKX_CLOCK_GATE_EN defined, clock the tkx register through a latch-based clock gate enabled only on cycles where tkx changes.
REQ-032 SHALL, without TKX_CLOCK_GATE_EN, use enable-muxed flops; cycle behaviour SHALL be identical in both builds.

Structure
REQ-033 SHALL place the state enum typedef, the legal-SDI_W check constant and the 128-bit tweakey width constant in shared package romulus_tkx_pkg.
REQ-034 SHALL use one sub-module, tkx_lane_reg: one SDI_W-wide lane register with load, shift and gate option, instantiated 128/SDI_W times.
REQ-035 SHALL fail elaboration for an illegal SDI_W or ROUNDS.

Verification
REQ-036 SHALL test a load with SDI_W=32, beats 0x00010203, 0x04050607, 0x08090A0B, 0x0C0D0E0F: tkx=0x000102030405060708090A0B0C0D0E0F and tkx_valid=1 after 4 accepted beats.
REQ-037 SHALL test a forward run with ROUNDS=40 and skinny_tkx=~tkx model: done pulses exactly 40 cycles after start is sampled, and tkx matches the model.
REQ-038 SHALL test start followed by rewind with an inverse model: tkx returns to its loaded value, with one done pulse per run.
REQ-039 SHALL test start and rewind high together in HOLD: RUN is entered and skinny_tkx_revert is never loaded.
REQ-040 SHALL test clear at round 17 of RUN, then rst low at beat 2 of LOAD: IDLE with tkx unchanged and no done, then tkx=0 and sdi_ready=1 immediately.
REQ-041 SHALL test a load with SDI_W=8 and 16 beats, with sdi_valid gaps and beats offered in HOLD: only accepted beats shift and tkx_valid rises after beat 16.

Source files
------------

// File: rtl/romulus_tkx_pkg.sv
// Shared types and constants for the tweakey update block.
package romulus_tkx_pkg;

  localparam int unsigned TKX_W = 128;

  // Bit k set means a serial beat width of 2**k bits is supported (8..128).
  localparam logic [7:0] SDI_W_LEGAL = 8'b1111_1000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_HOLD   = 3'd2,
    ST_RUN    = 3'd3,
    ST_REWIND = 3'd4
  } tkx_state_e;

  function automatic bit sdi_w_is_legal(input int unsigned w);
    for (int k = 0; k < 8; k++) begin
      if (w == (32'd1 << k)) return SDI_W_LEGAL[k];
    end
    return 1'b0;
  endfunction

endpackage

// File: rtl/tkx_lane_reg.sv
// One W-bit lane of the tweakey register: parallel load or serial shift.
// Build option TKX_CLOCK_GATE_EN: clock the lane through a latch-based
// clock gate instead of an enable mux; cycle behaviour is the same.
module tkx_lane_reg #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_d,
  input  logic         shift,
  input  logic [W-1:0] shift_d,
  output logic [W-1:0] q
);

  logic         en;
  logic [W-1:0] d;

  // Parallel load wins; the controller never asserts both together.
  always_comb begin
    en = load | shift;
    d  = load ? load_d : shift_d;
  end

`ifdef TKX_CLOCK_GATE_EN
  logic en_lat;
  logic gclk;

  // Enable is captured while clk is low so the gated clock cannot glitch.
  always_latch begin
    if (!clk) en_lat <= en;
  end

  assign gclk = clk & en_lat;

  // Gated-clock lane register.
  always_ff @(posedge gclk or negedge rst) begin
    if (!rst) q <= '0;
    else      q <= d;
  end
`else
  // Enable-muxed lane register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    q <= '0;
    else if (en) q <= d;
  end
`endif

endmodule

// File: rtl/tkx_update_param.sv
// Tweakey state register with serial load, forward run and inverse rewind.
// Build option TKX_CLOCK_GATE_EN selects latch-based clock gating of the
// lane registers (see tkx_lane_reg).
//
// state     | meaning
// ----------+-------------------------------------------------------
// ST_IDLE   | waiting for the first serial beat
// ST_LOAD   | accepting the remaining serial beats
// ST_HOLD   | tweakey valid, waiting for start or rewind
// ST_RUN    | loading skinny_tkx for ROUNDS cycles
// ST_REWIND | loading skinny_tkx_revert for ROUNDS cycles
module tkx_update_param
  import romulus_tkx_pkg::*;
#(
  parameter int SDI_W  = 32,
  parameter int ROUNDS = 40
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SDI_W-1:0]   sdi,
  input  logic               sdi_valid,
  output logic               sdi_ready,
  input  logic               start,
  input  logic               rewind,
  input  logic               clear,
  input  logic [TKX_W-1:0]   skinny_tkx,
  input  logic [TKX_W-1:0]   skinny_tkx_revert,
  output logic [TKX_W-1:0]   tkx,
  output logic               tkx_valid,
  output logic               done
);

  localparam int NB  = TKX_W / SDI_W;
  localparam int BCW = $clog2(NB + 1);
  localparam int RCW = $clog2(ROUNDS + 1);

  if (!sdi_w_is_legal(SDI_W)) begin : g_bad_sdi_w
    $error("tkx_update_param: SDI_W must be 8, 16, 32, 64 or 128");
  end
  if (ROUNDS < 1 || ROUNDS > 127) begin : g_bad_rounds
    $error("tkx_update_param: ROUNDS must be in 1..127");
  end

  tkx_state_e       state_q, state_d;
  logic [BCW-1:0]   beat_q, beat_d;
  logic [RCW-1:0]   rnd_q, rnd_d;
  logic             done_d;
  logic             accept;
  logic             shift_en;
  logic             load_en;
  logic             load_rev;
  logic [TKX_W-1:0] load_vec;

  // State, counters and the done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      rnd_q   <= '0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      rnd_q   <= rnd_d;
      done    <= done_d;
    end
  end

  // Next-state, counter and datapath control; clear overrides everything.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    rnd_d     = rnd_q;
    done_d    = 1'b0;
    shift_en  = 1'b0;
    load_en   = 1'b0;
    load_rev  = 1'b0;
    sdi_ready = (state_q == ST_IDLE) || (state_q == ST_LOAD);
    tkx_valid = (state_q == ST_HOLD);
    accept    = sdi_valid & sdi_ready;

    if (clear) begin
      state_d = ST_IDLE;
      beat_d  = '0;
      rnd_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            shift_en = 1'b1;
            state_d  = (NB == 1) ? ST_HOLD : ST_LOAD;
          end
        end
        ST_LOAD: begin
          // The IDLE beat is not counted here, so NB-2 marks the last beat.
          if (accept) begin
            shift_en = 1'b1;
            if (beat_q == BCW'(NB - 2)) state_d = ST_HOLD;
            else                        beat_d  = beat_q + 1'b1;
          end
        end
        ST_HOLD: begin
          if (start)       state_d = ST_RUN;
          else if (rewind) state_d = ST_REWIND;
        end
        ST_RUN, ST_REWIND: begin
          load_en  = 1'b1;
          load_rev = (state_q == ST_REWIND);
          if (rnd_q == RCW'(ROUNDS - 1)) begin
            state_d = ST_HOLD;
            done_d  = 1'b1;
          end else begin
            rnd_d = rnd_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase

      if (state_d != state_q) begin
        beat_d = '0;
        rnd_d  = '0;
      end
    end
  end

  assign load_vec = load_rev ? skinny_tkx_revert : skinny_tkx;

  // Lane 0 is the least significant word and takes the incoming beat.
  logic [SDI_W-1:0] lane_q [NB];

  for (genvar i = 0; i < NB; i++) begin : g_lane
    logic [SDI_W-1:0] shift_in;

    if (i == 0) begin : g_first
      assign shift_in = sdi;
    end else begin : g_chain
      assign shift_in = lane_q[i-1];
    end

    tkx_lane_reg #(.W(SDI_W)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .load    (load_en),
      .load_d  (load_vec[i*SDI_W +: SDI_W]),
      .shift   (shift_en),
      .shift_d (shift_in),
      .q       (lane_q[i])
    );

    assign tkx[i*SDI_W +: SDI_W] = lane_q[i];
  end

endmodule

// File: tb/tb_tkx_update_param.sv
// Scoreboard bench: dut_a (SDI_W=32, ROUNDS=40), dut_b (SDI_W=8, ROUNDS=5).
module tb_tkx_update_param;

  localparam int R_A = 40;
  localparam int R_B = 5;
  localparam logic [127:0] KC = 128'h5A3C_96E1_0F1E_2D3C_4B5A_6978_8796_A5B4;

  typedef struct {
    int           dut;
    int           kind;   // 0: load complete, 1: done pulse
    logic [127:0] tkx;
    int           cyc;    // -1: cycle not checked
    int           tag;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mode = 0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0]  sdi_a;
  logic         sdi_valid_a, sdi_ready_a, start_a, rewind_a, clear_a;
  logic [127:0] skin_a, skinr_a, tkx_a;
  logic         tkx_valid_a, done_a;

  logic [7:0]   sdi_b;
  logic         sdi_valid_b, sdi_ready_b, start_b, rewind_b, clear_b;
  logic [127:0] skin_b, skinr_b, tkx_b;
  logic         tkx_valid_b, done_b;

  // Environment round functions: mode 0 is bitwise NOT, mode 1 rotate-xor.
  function automatic logic [127:0] fwd(input logic [127:0] x, input int m);
    if (m == 0) return ~x;
    return {x[126:0], x[127]} ^ KC;
  endfunction

  function automatic logic [127:0] inv(input logic [127:0] y, input int m);
    logic [127:0] t;
    if (m == 0) return ~y;
    t = y ^ KC;
    return {t[0], t[127:1]};
  endfunction

  function automatic logic [127:0] apply(input logic [127:0] x, input int m,
                                         input int n, input bit rev);
    logic [127:0] y;
    y = x;
    for (int i = 0; i < n; i++) y = rev ? inv(y, m) : fwd(y, m);
    return y;
  endfunction

  assign skin_a  = fwd(tkx_a, mode);
  assign skinr_a = inv(tkx_a, mode);
  assign skin_b  = fwd(tkx_b, mode);
  assign skinr_b = inv(tkx_b, mode);

  tkx_update_param #(.SDI_W(32), .ROUNDS(R_A)) dut_a (
    .clk(clk), .rst(rst), .sdi(sdi_a), .sdi_valid(sdi_valid_a),
    .sdi_ready(sdi_ready_a), .start(start_a), .rewind(rewind_a),
    .clear(clear_a), .skinny_tkx(skin_a), .skinny_tkx_revert(skinr_a),
    .tkx(tkx_a), .tkx_valid(tkx_valid_a), .done(done_a)
  );

  tkx_update_param #(.SDI_W(8), .ROUNDS(R_B)) dut_b (
    .clk(clk), .rst(rst), .sdi(sdi_b), .sdi_valid(sdi_valid_b),
    .sdi_ready(sdi_ready_b), .start(start_b), .rewind(rewind_b),
    .clear(clear_b), .skinny_tkx(skin_b), .skinny_tkx_revert(skinr_b),
    .tkx(tkx_b), .tkx_valid(tkx_valid_b), .done(done_b)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic sb_pop(input int dut, input int kind, input logic [127:0] act);
    exp_t e;
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $display("FAIL sb_unexpected: dut%0d kind%0d cyc%0d tkx %h, required no event",
               dut, kind, cyc, act);
      return;
    end
    e = sbq.pop_front();
    if (e.dut != dut || e.kind != kind || act !== e.tkx || (e.cyc >= 0 && cyc != e.cyc)) begin
      errors++;
      $display("FAIL sb_event%0d: got dut%0d kind%0d cyc%0d tkx %h, required dut%0d kind%0d cyc%0d tkx %h",
               e.tag, dut, kind, cyc, act, e.dut, e.kind, e.cyc, e.tkx);
    end
  endtask

  task automatic push(input int dut, input int kind, input logic [127:0] t, input int c, input int tag);
    exp_t e;
    e.dut = dut; e.kind = kind; e.tkx = t; e.cyc = c; e.tag = tag;
    sbq.push_back(e);
  endtask

  // Cycle counter used to time done pulses.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every done pulse or tkx_valid rise is matched against the queue.
  logic pv_a = 1'b0, pv_b = 1'b0;
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (done_a)                    sb_pop(0, 1, tkx_a);
      else if (tkx_valid_a && !pv_a) sb_pop(0, 0, tkx_a);
      if (done_b)                    sb_pop(1, 1, tkx_b);
      else if (tkx_valid_b && !pv_b) sb_pop(1, 0, tkx_b);
      pv_a = tkx_valid_a;
      pv_b = tkx_valid_b;
    end else begin
      pv_a = 1'b0;
      pv_b = 1'b0;
    end
  end

  logic [127:0] ma, mb;
  int tagn = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_a(input logic [127:0] val);
    push(0, 0, val, -1, tagn++);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("ready_during_load_a", {127'd0, sdi_ready_a}, 128'd1);
      sdi_a       = val[127-32*i -: 32];
      sdi_valid_a = 1'b1;
    end
    tick();
    sdi_valid_a = 1'b0;
    chk("load_a_valid", {127'd0, tkx_valid_a}, 128'd1);
    chk("load_a_tkx", tkx_a, val);
    ma = val;
  endtask

  task automatic op_a(input bit rev, input bit both);
    logic [127:0] e;
    e = apply(ma, mode, R_A, rev);
    tick();
    start_a  = ~rev;
    rewind_a = rev | both;
    push(0, 1, e, cyc + 1 + R_A, tagn++);
    tick();
    start_a  = 1'b0;
    rewind_a = 1'b0;
    repeat (R_A + 3) tick();
    chk("op_a_tkx", tkx_a, e);
    ma = e;
  endtask

  task automatic clear_a_now();
    tick();
    clear_a = 1'b1;
    tick();
    clear_a = 1'b0;
  endtask

  initial begin
    logic [127:0] hold_val, v;
    int acc;
    rst = 1'b0;
    sdi_a = '0; sdi_valid_a = 0; start_a = 0; rewind_a = 0; clear_a = 0;
    sdi_b = '0; sdi_valid_b = 0; start_b = 0; rewind_b = 0; clear_b = 0;
    #1;
    chk("rst_tkx", tkx_a, 128'd0);
    chk("rst_ready", {127'd0, sdi_ready_a}, 128'd1);
    chk("rst_valid", {127'd0, tkx_valid_a}, 128'd0);
    chk("rst_done", {127'd0, done_a}, 128'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Fixed load, then a beat offered in HOLD must be ignored.
    load_a(128'h0001_0203_0405_0607_0809_0A0B_0C0D_0E0F);
    sdi_a = 32'hDEAD_BEEF; sdi_valid_a = 1'b1;
    tick(); tick();
    sdi_valid_a = 1'b0;
    chk("hold_ready_low", {127'd0, sdi_ready_a}, 128'd0);
    chk("hold_ignores_beat", tkx_a, ma);

    // Forward run with the NOT model.
    mode = 0;
    op_a(1'b0, 1'b0);

    // Forward then rewind with rotate-xor model returns to the loaded value.
    mode = 1;
    hold_val = ma;
    op_a(1'b0, 1'b0);
    op_a(1'b1, 1'b0);
    chk("rewind_restores", tkx_a, hold_val);

    // start and rewind together: forward wins.
    op_a(1'b0, 1'b1);

    // Clear at round 17: 17 rounds applied, IDLE, no done.
    v = ma;
    tick();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (17) tick();
    clear_a = 1'b1;
    tick();
    clear_a = 1'b0;
    chk("clear_tkx", tkx_a, apply(v, mode, 17, 1'b0));
    chk("clear_ready", {127'd0, sdi_ready_a}, 128'd1);
    chk("clear_valid", {127'd0, tkx_valid_a}, 128'd0);
    start_a = 1'b1; rewind_a = 1'b1;
    repeat (R_A + 5) tick();
    start_a = 1'b0; rewind_a = 1'b0;
    chk("idle_holds_tkx", tkx_a, apply(v, mode, 17, 1'b0));

    // Reset during LOAD at beat 2.
    tick(); sdi_a = $urandom; sdi_valid_a = 1'b1;
    tick(); sdi_a = $urandom;
    tick(); sdi_valid_a = 1'b0;
    rst = 1'b0;
    #1;
    chk("midload_rst_tkx", tkx_a, 128'd0);
    chk("midload_rst_ready", {127'd0, sdi_ready_a}, 128'd1);
    chk("midload_rst_valid", {127'd0, tkx_valid_a}, 128'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Random loads and operations on dut_a.
    for (int n = 0; n < 4; n++) begin
      v = {$urandom, $urandom, $urandom, $urandom};
      mode = n % 2;
      load_a(v);
      op_a(n[0], 1'b0);
      op_a(~n[0], n[1]);
      clear_a_now();
    end

    // Byte-wide load with valid gaps, then beats offered in HOLD.
    mb = '0;
    acc = 0;
    push(1, 0, 128'd0, -1, tagn++);
    while (acc < 16) begin
      tick();
      chk("b_valid_before_full", {127'd0, tkx_valid_b}, 128'd0);
      if ($urandom_range(0, 1) == 1) begin
        chk("b_ready", {127'd0, sdi_ready_b}, 128'd1);
        sdi_b = 8'($urandom);
        sdi_valid_b = 1'b1;
        mb = {mb[119:0], sdi_b};
        acc++;
      end else begin
        sdi_b = 8'($urandom);
        sdi_valid_b = 1'b0;
      end
    end
    sbq[sbq.size()-1].tkx = mb;
    tick();
    sdi_valid_b = 1'b1;
    chk("b_load_valid", {127'd0, tkx_valid_b}, 128'd1);
    chk("b_load_tkx", tkx_b, mb);
    for (int i = 0; i < 4; i++) begin
      sdi_b = 8'($urandom);
      tick();
      chk("b_hold_ready", {127'd0, sdi_ready_b}, 128'd0);
    end
    sdi_valid_b = 1'b0;
    chk("b_hold_tkx", tkx_b, mb);

    // Short rewind on dut_b.
    mode = 1;
    tick();
    rewind_b = 1'b1;
    push(1, 1, apply(mb, mode, R_B, 1'b1), cyc + 1 + R_B, tagn++);
    tick();
    rewind_b = 1'b0;
    repeat (R_B + 4) tick();
    chk("b_rewind_tkx", tkx_b, apply(mb, mode, R_B, 1'b1));

    repeat (5) tick();
    while (sbq.size() != 0) begin
      exp_t e;
      e = sbq.pop_front();
      checks++;
      errors++;
      $display("FAIL sb_missing%0d: got no event, required dut%0d kind%0d tkx %h",
               e.tag, e.dut, e.kind, e.tkx);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
